rf_wb_arbiter: RTL and testbench

Write-port arbiter and scheduler for the 32x32 register file (`rf`), which has a single write port. Shares that port between the in-order pipeline writeback and a multi-cycle result source (mul/div, load return). The multi-cycle source gets a small queue and starvation protection. An optional pending-register scoreboard raises a hazard for sources whose long-latency result has not yet been written. Sits between the writeback stage and `rf` and drives `rf`'s `RegWrite`/`rc`/`dc` directly.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/wb_fifo.sv | 78 +++++++
 rtl/rf_wb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the register-file writeback path.
//   REG_AW / DATA_W : register address and data widths (32 x 32 register file)
//   NUM_REGS        : number of architectural registers
//   REG_ZERO        : the hardwired-zero register; writes to it are dropped
//   wb_req_t        : one writeback request {we, rc, dc}
//   wb_src_e        : which source produced the word held in the output stage
//   is_wb_req()     : true for a real write (enable set and target is not r0)
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 1 << REG_AW;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rc;
    logic [DATA_W-1:0] dc;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_PIPE  = 1'b0,
    WB_SRC_QUEUE = 1'b1
  } wb_src_e;

  function automatic logic is_wb_req(input logic we, input logic [REG_AW-1:0] rc);
    return we && (rc != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Parameterised synchronous FIFO for queued multi-cycle results. Show-ahead:
// dout_o always presents the head entry while the FIFO is non-empty.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : write din_i; ignored while full, even if pop_i is also set
//   pop_i      : discard the head entry; ignored while empty
//   din_i      : entry to write
//   dout_o     : head entry
//   count_o    : number of entries held (0..DEPTH)
//   empty_o    : count_o == 0
// -----------------------------------------------------------------------------
module wb_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = REG_AW + DATA_W,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until count_q says it is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback and a queued multi-cycle result source (mul/div, load return),
// with starvation protection for the queue and an optional pending-register
// scoreboard.
//
// Parameters
//   DEPTH        : multi-cycle result queue entries (power of two, >= 2)
//   STARVE_LIMIT : consecutive lost cycles before the queue head is forced out
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   p_we, p_rc, p_dc         : pipeline writeback request
//   m_valid, m_rc, m_dc      : multi-cycle result; m_ready = queue can accept
//   issue_valid, issue_rc    : long-latency issue, reserves its destination
//   chk_ra, chk_rb           : decode-stage sources; hazard = one is pending
//   stall                    : registered; pipeline must hold its writeback
//   RegWrite, rc, dc         : registered register-file write port
// Configuration
//   RF_WB_SCOREBOARD_EN : when defined, builds the 32-bit pending scoreboard;
//                         otherwise issue_* are ignored and hazard is 0.
// -----------------------------------------------------------------------------
module rf_wb_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_we,
  input  logic [REG_AW-1:0] p_rc,
  input  logic [DATA_W-1:0] p_dc,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [REG_AW-1:0] m_rc,
  input  logic [DATA_W-1:0] m_dc,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rc,
  input  logic [REG_AW-1:0] chk_ra,
  input  logic [REG_AW-1:0] chk_rb,
  output logic              hazard,
  output logic              stall,
  output logic              RegWrite,
  output logic [REG_AW-1:0] rc,
  output logic [DATA_W-1:0] dc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  // ---------------------------------------------------------------------------
  // Multi-cycle result queue
  // ---------------------------------------------------------------------------
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic [REG_AW-1:0] q_rc;
  logic [DATA_W-1:0] q_dc;
  logic              m_take;
  logic              m_push;
  logic              drain;

  // Acceptance depends on count only: a full queue refuses even while draining.
  assign m_ready = (q_count < CW'(DEPTH));
  assign m_take  = m_valid && m_ready;
  // r0 results are consumed from the source but never queued.
  assign m_push  = m_take && (m_rc != REG_ZERO);

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (REG_AW + DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (m_push),
    .pop_i   (drain),
    .din_i   ({m_rc, m_dc}),
    .dout_o  ({q_rc, q_dc}),
    .count_o (q_count),
    .empty_o (q_empty)
  );

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic          p_req;
  logic          pipe_win;
  logic          stall_q, stall_d;
  logic [SW-1:0] starve_q, starve_d;

  assign p_req = is_wb_req(p_we, p_rc);

  // A registered stall forces the head out ahead of the pipeline; otherwise
  // the pipeline wins and the queue only drains in pipeline-idle cycles.
  assign drain    = !q_empty && (stall_q || !p_req);
  assign pipe_win = p_req && !drain;

  always_comb begin
    starve_d = starve_q;
    if (q_empty || drain) begin
      starve_d = '0;
    end else if (pipe_win) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Reaching the limit raises stall for exactly one cycle; the forced drain
  // in that cycle clears the counter, which in turn drops stall again.
  assign stall_d = (starve_d == SW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign stall = stall_q;

  // ---------------------------------------------------------------------------
  // Output register to the register-file write port
  // ---------------------------------------------------------------------------
  wb_req_t wb_q, wb_d;
  wb_src_e src_q, src_d;

  always_comb begin
    wb_d    = wb_q;
    wb_d.we = 1'b0;
    src_d   = src_q;
    if (drain) begin
      wb_d  = '{we: 1'b1, rc: q_rc, dc: q_dc};
      src_d = WB_SRC_QUEUE;
    end else if (pipe_win) begin
      wb_d  = '{we: 1'b1, rc: p_rc, dc: p_dc};
      src_d = WB_SRC_PIPE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q  <= '0;
      src_q <= WB_SRC_PIPE;
    end else begin
      wb_q  <= wb_d;
      src_q <= src_d;
    end
  end

  assign RegWrite = wb_q.we;
  assign rc       = wb_q.rc;
  assign dc       = wb_q.dc;

  // ---------------------------------------------------------------------------
  // Pending-register scoreboard
  // ---------------------------------------------------------------------------
`ifdef RF_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pend_q, pend_d;

  // Retirement keys off the output stage, i.e. the cycle rf actually writes,
  // so hazard stays up through that write. Reservation is applied last so a
  // same-cycle set overrides the clear.
  always_comb begin
    pend_d = pend_q;
    if (wb_q.we && (src_q == WB_SRC_QUEUE)) begin
      pend_d[wb_q.rc] = 1'b0;
    end
    if (issue_valid && (issue_rc != REG_ZERO)) begin
      pend_d[issue_rc] = 1'b1;
    end
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign hazard = pend_q[chk_ra] | pend_q[chk_rb];
`else
  logic unused_sb;
  assign unused_sb = ^{issue_valid, issue_rc, chk_ra, chk_rb, src_q};
  assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        p_we;
  logic [4:0]  p_rc;
  logic [31:0] p_dc;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_rc;
  logic [31:0] m_dc;
  logic        issue_valid;
  logic [4:0]  issue_rc;
  logic [4:0]  chk_ra;
  logic [4:0]  chk_rb;
  logic        hazard;
  logic        stall;
  logic        RegWrite;
  logic [4:0]  rc;
  logic [31:0] dc;

  rf_wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p_we        (p_we),
    .p_rc        (p_rc),
    .p_dc        (p_dc),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_rc        (m_rc),
    .m_dc        (m_dc),
    .issue_valid (issue_valid),
    .issue_rc    (issue_rc),
    .chk_ra      (chk_ra),
    .chk_rb      (chk_rb),
    .hazard      (hazard),
    .stall       (stall),
    .RegWrite    (RegWrite),
    .rc          (rc),
    .dc          (dc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queue of pending results, a lost-cycle tally and a
  // per-register pending flag; predicts the registered outputs.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [4:0]  rc;
    logic [31:0] dc;
  } ent_t;

  ent_t        mq[$];
  int          lost;
  bit          e_stall;
  bit          e_we;
  bit          e_from_q;
  logic [4:0]  e_rc;
  logic [31:0] e_dc;
  bit          pend[32];

  task automatic model_reset();
    mq.delete();
    lost     = 0;
    e_stall  = 0;
    e_we     = 0;
    e_from_q = 0;
    e_rc     = '0;
    e_dc     = '0;
    foreach (pend[i]) pend[i] = 0;
  endtask

  task automatic model_check();
    bit exp_haz;
    exp_haz = SB && (pend[chk_ra] || pend[chk_rb]);
    chk("model_RegWrite", {31'd0, RegWrite}, {31'd0, e_we});
    chk("model_rc", {27'd0, rc}, {27'd0, e_rc});
    chk("model_dc", dc, e_dc);
    chk("model_stall", {31'd0, stall}, {31'd0, e_stall});
    chk("model_m_ready", {31'd0, m_ready}, {31'd0, (mq.size() < DEPTH)});
    chk("model_hazard", {31'd0, hazard}, {31'd0, exp_haz});
  endtask

  task automatic model_update();
    bit   preq, busy, take_q, accept;
    ent_t h;
    if (rst) begin
      model_reset();
    end else begin
      preq   = p_we && (p_rc != 5'd0);
      busy   = (mq.size() > 0);
      take_q = busy && (e_stall || !preq);
      accept = m_valid && (mq.size() < DEPTH);
      if (e_we && e_from_q) pend[e_rc] = 0;
      if (issue_valid && issue_rc != 5'd0) pend[issue_rc] = 1;
      if (take_q) begin
        h        = mq.pop_front();
        e_we     = 1;
        e_rc     = h.rc;
        e_dc     = h.dc;
        e_from_q = 1;
        lost     = 0;
      end else if (preq) begin
        e_we     = 1;
        e_rc     = p_rc;
        e_dc     = p_dc;
        e_from_q = 0;
        lost     = busy ? lost + 1 : 0;
      end else begin
        e_we = 0;
        lost = 0;
      end
      e_stall = (lost == LIMIT);
      if (accept && m_rc != 5'd0) mq.push_back('{rc: m_rc, dc: m_dc});
    end
  endtask

  // Inputs are set at posedge+1; outputs are compared 1 time unit later.
  task automatic step();
    #1;
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        pwe;
    logic [4:0]  prc;
    logic [31:0] pdc;
    logic        ewe;
    logic [4:0]  erc;
    logic [31:0] edc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; p_we = 0; p_rc = '0; p_dc = '0;
    m_valid = 0; m_rc = '0; m_dc = '0;
    issue_valid = 0; issue_rc = '0; chk_ra = '0; chk_rb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_rc", {27'd0, rc}, 32'd0);
    chk("rst_dc", dc, 32'd0);
    chk("rst_m_ready", {31'd0, m_ready}, 32'd1);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Pipeline-only vectors: output one cycle after the request
    tbl[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  32'hDEADBEEF};
    tbl[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd3,  32'hDEADBEEF};
    tbl[2] = '{1'b0, 5'd9,  32'h0000AAAA, 1'b0, 5'd3,  32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
    tbl[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
    tbl[5] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd1,  32'h00000000};
    for (int i = 0; i < 6; i++) begin
      p_we = tbl[i].pwe; p_rc = tbl[i].prc; p_dc = tbl[i].pdc;
      step();
      chk($sformatf("tbl%0d_we", i), {31'd0, RegWrite}, {31'd0, tbl[i].ewe});
      chk($sformatf("tbl%0d_rc", i), {27'd0, rc}, {27'd0, tbl[i].erc});
      chk($sformatf("tbl%0d_dc", i), dc, tbl[i].edc);
    end

    // Starvation: queue r5, r6 while the pipeline writes r2 every cycle
    p_we = 1; p_rc = 5'd2; p_dc = 32'h1000;
    m_valid = 1; m_rc = 5'd5; m_dc = 32'h11;
    step();
    chk("stv_pipe_first", {27'd0, rc}, 32'd2);
    m_rc = 5'd6; m_dc = 32'h22;
    step();
    m_rc = 5'd7; m_dc = 32'h33;
    chk("stv_m_ready_full", {31'd0, m_ready}, 32'd0);
    step();
    m_valid = 0;
    step();
    chk("stv_stall_pre", {31'd0, stall}, 32'd0);
    step();
    chk("stv_stall_on", {31'd0, stall}, 32'd1);
    chk("stv_pipe_rc", {27'd0, rc}, 32'd2);
    step();
    chk("stv_r5_we", {31'd0, RegWrite}, 32'd1);
    chk("stv_r5_rc", {27'd0, rc}, 32'd5);
    chk("stv_r5_dc", dc, 32'h11);
    chk("stv_stall_off", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stv2_lost%0d_rc", i), {27'd0, rc}, 32'd2);
      chk($sformatf("stv2_lost%0d_stall", i), {31'd0, stall}, {31'd0, (i == 3)});
    end
    step();
    chk("stv_r6_rc", {27'd0, rc}, 32'd6);
    chk("stv_r6_dc", dc, 32'h22);
    p_we = 0;
    step();
    chk("stv_idle_we", {31'd0, RegWrite}, 32'd0);

    // Same-cycle pipeline and queue requests
    p_we = 1; p_rc = 5'd4; p_dc = 32'hAA;
    m_valid = 1; m_rc = 5'd8; m_dc = 32'hBB;
    step();
    chk("both_pipe_rc", {27'd0, rc}, 32'd4);
    chk("both_pipe_dc", dc, 32'hAA);
    p_we = 0; m_valid = 0;
    step();
    chk("both_m_we", {31'd0, RegWrite}, 32'd1);
    chk("both_m_rc", {27'd0, rc}, 32'd8);
    chk("both_m_dc", dc, 32'hBB);
    step();

    // FIFO order over 4 pushes
    for (int i = 0; i < 4; i++) begin
      m_valid = 1; m_rc = 5'(10 + i); m_dc = 32'h100 + 32'(i);
      step();
      chk($sformatf("fifo%0d_we", i), {31'd0, RegWrite}, {31'd0, (i > 0)});
      if (i > 0) chk($sformatf("fifo%0d_rc", i), {27'd0, rc}, 32'(9 + i));
    end
    m_valid = 0;
    step();
    chk("fifo_last_rc", {27'd0, rc}, 32'd13);
    chk("fifo_last_dc", dc, 32'h103);
    step();
    chk("fifo_drained_we", {31'd0, RegWrite}, 32'd0);

    // Scoreboard
    issue_valid = 1; issue_rc = 5'd7;
    step();
    issue_valid = 0; chk_ra = 5'd7;
    #1 chk("sb_set", {31'd0, hazard}, {31'd0, SB});
    p_we = 1; p_rc = 5'd7; p_dc = 32'h70;
    step();
    p_we = 0; chk_ra = 5'd0; chk_rb = 5'd7;
    #1 chk("sb_pipe_write", {31'd0, hazard}, {31'd0, SB});
    step();
    chk("sb_after_pipe", {31'd0, hazard}, {31'd0, SB});
    m_valid = 1; m_rc = 5'd7; m_dc = 32'h77;
    step();
    m_valid = 0;
    step();
    chk("sb_rf_write_rc", {27'd0, rc}, 32'd7);
    chk("sb_rf_write_hold", {31'd0, hazard}, {31'd0, SB});
    step();
    chk("sb_cleared", {31'd0, hazard}, 32'd0);

    // Reset with two entries queued and r7 pending
    issue_valid = 1; issue_rc = 5'd7;
    p_we = 1; p_rc = 5'd3; p_dc = 32'h5;
    m_valid = 1; m_rc = 5'd9; m_dc = 32'h99;
    step();
    issue_valid = 0; m_rc = 5'd10;
    step();
    m_valid = 0;
    chk("mid_full", {31'd0, m_ready}, 32'd0);
    chk("mid_pending", {31'd0, hazard}, {31'd0, SB});
    rst = 1; p_we = 0;
    step();
    rst = 0;
    chk("mid_rst_m_ready", {31'd0, m_ready}, 32'd1);
    chk("mid_rst_hazard", {31'd0, hazard}, 32'd0);
    chk("mid_rst_we", {31'd0, RegWrite}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    step();
    chk("mid_rst_empty", {31'd0, RegWrite}, 32'd0);
    chk_rb = 5'd0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 249) == 0);
      p_we        = ($urandom_range(0, 3) != 0);
      p_rc        = 5'($urandom_range(0, 31));
      p_dc        = $urandom;
      m_valid     = ($urandom_range(0, 1) == 1);
      m_rc        = 5'($urandom_range(0, 7));
      m_dc        = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rc    = 5'($urandom_range(0, 7));
      chk_ra      = 5'($urandom_range(0, 7));
      chk_rb      = 5'($urandom_range(0, 7));
      step();
    end
    rst = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
